// File: rtl/ro_ctrl_pkg.sv
// ro_ctrl_pkg
//   Shared definitions for the ring-oscillator sample controller:
//   default widths and the controller state encoding.
//   No ports (package).
package ro_ctrl_pkg;

  localparam int DEF_SIZE_WIDTH = 17;  // width of sample count / window length
  localparam int DEF_CNT_WIDTH  = 32;  // width of ring-oscillator count / sample

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_COLLECT = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_PUSH    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/ro_window_timer.sv
// ro_window_timer
//   Loadable down-counter that times the ring-oscillator counting window.
//   Ports:
//     clk        - clock
//     rst        - synchronous active-high reset
//     i_load     - load i_load_val into the counter (has priority over i_dec)
//     i_load_val - value to load (window length minus one)
//     i_dec      - decrement by one; holds at zero
//     o_zero     - counter is zero (last cycle of the window)
module ro_window_timer #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ro_sample_ctrl.sv
// ro_sample_ctrl
//   Runs a burst of ring-oscillator measurements. Each sample: clear the
//   RO counter (CLEAR), enable it for C cycles (COLLECT), let it settle one
//   cycle and capture the count (SETTLE), then offer it downstream with a
//   valid/ready handshake (PUSH). After N samples the run ends in DONE.
//   Ports:
//     clk, rst        - clock, synchronous active-high reset
//     go              - one-cycle start pulse (accepted in IDLE/DONE only)
//     num_samples     - N, samples per run (latched at go)
//     collect_cycles  - C, window length in clk cycles (latched, 0 -> 1)
//     ro_count        - ring-oscillator count, synchronous to clk
//     ro_en, ro_clr   - RO counter enable / clear
//     smp_valid/data  - sample offered downstream
//     smp_ready       - downstream accepts the sample
//     busy, done      - run in progress / run completed
module ro_sample_ctrl
  import ro_ctrl_pkg::*;
#(
  parameter int SIZE_WIDTH = DEF_SIZE_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [SIZE_WIDTH-1:0] num_samples,
  input  logic [SIZE_WIDTH-1:0] collect_cycles,
  input  logic [CNT_WIDTH-1:0]  ro_count,
  output logic                  ro_en,
  output logic                  ro_clr,
  output logic                  smp_valid,
  output logic [CNT_WIDTH-1:0]  smp_data,
  input  logic                  smp_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [SIZE_WIDTH-1:0] ONE_S = {{(SIZE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SIZE_WIDTH:0]   ONE_C = {{SIZE_WIDTH{1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_next;
  logic [SIZE_WIDTH-1:0] r_num;
  logic [SIZE_WIDTH-1:0] r_coll;
  // One bit wider than N so N = 2**SIZE_WIDTH-1 never wraps.
  logic [SIZE_WIDTH:0]   r_smp_cnt;
  logic [CNT_WIDTH-1:0]  r_smp_data;

  logic                  w_go_accept;
  logic                  w_xfer;
  logic                  w_last_smp;
  logic [SIZE_WIDTH:0]   w_smp_cnt_inc;
  logic [SIZE_WIDTH-1:0] w_coll_eff;
  logic [SIZE_WIDTH-1:0] w_win_load_val;
  logic                  w_win_load;
  logic                  w_win_dec;
  logic                  w_win_zero;

  assign w_go_accept    = go && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_xfer         = (r_state == ST_PUSH) && smp_ready;
  assign w_smp_cnt_inc  = r_smp_cnt + ONE_C;
  assign w_last_smp     = (w_smp_cnt_inc == {1'b0, r_num});
  // A zero-length window is treated as a single cycle.
  assign w_coll_eff     = (collect_cycles == '0) ? ONE_S : collect_cycles;
  // Timer counts C-1 down to 0, so the zero flag marks the C-th COLLECT cycle.
  assign w_win_load_val = r_coll - ONE_S;
  assign w_win_load     = (r_state == ST_CLEAR);
  assign w_win_dec      = (r_state == ST_COLLECT);

  ro_window_timer #(
    .W (SIZE_WIDTH)
  ) u_win_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_win_load),
    .i_load_val (w_win_load_val),
    .i_dec      (w_win_dec),
    .o_zero     (w_win_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (go) begin
          w_state_next = (num_samples == '0) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR:   w_state_next = ST_COLLECT;
      ST_COLLECT: if (w_win_zero) w_state_next = ST_SETTLE;
      ST_SETTLE:  w_state_next = ST_PUSH;
      ST_PUSH: begin
        if (smp_ready) begin
          w_state_next = w_last_smp ? ST_DONE : ST_CLEAR;
        end
      end
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    ro_en     = 1'b0;
    ro_clr    = 1'b0;
    smp_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (r_state)
      ST_CLEAR:   begin ro_clr    = 1'b1; busy = 1'b1; end
      ST_COLLECT: begin ro_en     = 1'b1; busy = 1'b1; end
      ST_SETTLE:  begin                   busy = 1'b1; end
      ST_PUSH:    begin smp_valid = 1'b1; busy = 1'b1; end
      ST_DONE:    begin done      = 1'b1;              end
      default:    begin                                end
    endcase
  end

  // Run parameters, sample counter and captured sample
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num      <= '0;
      r_coll     <= ONE_S;
      r_smp_cnt  <= '0;
      r_smp_data <= '0;
    end else begin
      if (w_go_accept) begin
        r_num     <= num_samples;
        r_coll    <= w_coll_eff;
        r_smp_cnt <= '0;
      end else if (w_xfer) begin
        r_smp_cnt <= w_smp_cnt_inc;
      end
      // The counter has been idle for a full cycle here, so its value is final.
      if (r_state == ST_SETTLE) begin
        r_smp_data <= ro_count;
      end
    end
  end

  assign smp_data = r_smp_data;

endmodule

// File: tb/tb_ro_sample_ctrl.sv
module tb_ro_sample_ctrl;
  localparam int SW = 17;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [SW-1:0] num_samples;
  logic [SW-1:0] collect_cycles;
  logic [CW-1:0] ro_count;
  logic          ro_en;
  logic          ro_clr;
  logic          smp_valid;
  logic [CW-1:0] smp_data;
  logic          smp_ready;
  logic          busy;
  logic          done;

  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] exp_q[$];
  int            exp_en_run = 0;
  int            clr_total = 0;

  always #5 clk = ~clk;

  ro_sample_ctrl #(
    .SIZE_WIDTH (SW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .go             (go),
    .num_samples    (num_samples),
    .collect_cycles (collect_cycles),
    .ro_count       (ro_count),
    .ro_en          (ro_en),
    .ro_clr         (ro_clr),
    .smp_valid      (smp_valid),
    .smp_data       (smp_data),
    .smp_ready      (smp_ready),
    .busy           (busy),
    .done           (done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ring-oscillator counter model: each clear loads (clear number)*256,
  // each enabled cycle adds one. A sample is therefore 256*p + C.
  initial begin
    ro_count = '0;
    forever begin
      @(posedge clk);
      if (ro_clr === 1'b1) begin
        ro_count  <= CW'((clr_total + 1) * 256);
        clr_total <= clr_total + 1;
      end else if (ro_en === 1'b1) begin
        ro_count  <= ro_count + 32'd1;
      end
    end
  end

  // Monitor: protocol checks and scoreboard pop on every transfer.
  initial begin
    logic          prev_clr;
    logic          prev_valid;
    logic          prev_ready;
    logic [CW-1:0] prev_data;
    logic [CW-1:0] exp_v;
    logic          in_sample;
    int            en_run;
    int            n_xfer;
    prev_clr = 0; prev_valid = 0; prev_ready = 0; prev_data = '0;
    in_sample = 0; en_run = 0; n_xfer = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        in_sample = 0;
        en_run = 0;
      end else begin
        if (ro_clr === 1'b1) begin
          chk("clr_single_cycle", 64'(prev_clr), 64'(0));
          chk("clr_after_xfer", 64'(in_sample), 64'(0));
          in_sample = 1;
        end
        if (ro_en === 1'b1) begin
          en_run++;
        end else if (en_run > 0) begin
          chk("en_window_len", 64'(en_run), 64'(exp_en_run));
          en_run = 0;
        end
        if (smp_valid === 1'b1 && prev_valid && !prev_ready) begin
          chk("data_hold", 64'(smp_data), 64'(prev_data));
        end
        if (smp_valid === 1'b1 && smp_ready === 1'b1) begin
          n_xfer++;
          $display("sample %0d data=%0d", n_xfer, smp_data);
          if (exp_q.size() == 0) begin
            chk("unexpected_sample", 64'(1), 64'(0));
          end else begin
            exp_v = exp_q.pop_front();
            chk("sample_data", 64'(smp_data), 64'(exp_v));
          end
          in_sample = 0;
        end
      end
      prev_clr   = ro_clr;
      prev_valid = smp_valid;
      prev_ready = smp_ready;
      prev_data  = smp_data;
    end
  end

  // Issue one run; latency counts clock edges from the go edge until done.
  task automatic run(input int n, input int c, input int stall, input int exp_lat,
                     input string name);
    int lat;
    int st;
    st = stall;
    smp_ready = 1'b1;
    num_samples = SW'(n);
    collect_cycles = SW'(c);
    exp_en_run = (c == 0) ? 1 : c;
    go = 1'b1;
    tick();
    go = 1'b0;
    lat = 1;
    // Mid-run changes on the size inputs must not matter.
    num_samples = 17'd7;
    collect_cycles = 17'd2;
    while (done !== 1'b1 && lat < 400) begin
      if (smp_valid === 1'b1 && st > 0) begin
        smp_ready = 1'b0;
        st--;
      end else begin
        smp_ready = 1'b1;
      end
      tick();
      lat++;
    end
    $display("run %s latency=%0d", name, lat);
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_idle_at_done"}, 64'(busy), 64'(0));
    smp_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int cnt;
    rst = 1'b1; go = 1'b0; smp_ready = 1'b1;
    num_samples = '0; collect_cycles = '0;
    tick();
    tick();
    // go coincident with reset is ignored
    num_samples = 17'd3; collect_cycles = 17'd2; go = 1'b1;
    tick();
    rst = 1'b0; go = 1'b0;
    chk("reset_outputs", 64'({ro_en, ro_clr, smp_valid, busy, done, smp_data}), 64'(0));
    tick();
    chk("go_with_rst_ignored", 64'({busy, done, ro_clr}), 64'(0));

    // N=3, C=10: samples 256+10, 512+10, 768+10; done 40 cycles after go
    exp_q.push_back(32'd266); exp_q.push_back(32'd522); exp_q.push_back(32'd778);
    run(3, 10, 0, 40, "t1_n3_c10");
    chk("t1_done", 64'(done), 64'(1));

    // N=0: done one cycle after go, nothing else
    run(0, 5, 0, 1, "t2_n0");
    chk("t2_done", 64'(done), 64'(1));

    // N=2, C=0 (one-cycle window): 1024+1, 1280+1; 1+2*4 cycles
    exp_q.push_back(32'd1025); exp_q.push_back(32'd1281);
    run(2, 0, 0, 9, "t3_c0");

    // N=2, C=4, 5 stall cycles in first PUSH: 1536+4, 1792+4; 1+2*7+5 cycles
    exp_q.push_back(32'd1540); exp_q.push_back(32'd1796);
    run(2, 4, 5, 20, "t4_stall");

    // Second go during COLLECT is ignored; reset in PUSH aborts the run
    smp_ready = 1'b0;
    exp_en_run = 6;
    num_samples = 17'd2; collect_cycles = 17'd6; go = 1'b1;
    tick();
    go = 1'b0;
    lat = 1;
    repeat (3) tick();
    lat = 4;
    chk("t5_in_collect", 64'({ro_en, busy}), 64'(3));
    num_samples = 17'd5; collect_cycles = 17'd1; go = 1'b1;
    tick();
    go = 1'b0;
    lat = 5;
    while (smp_valid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    chk("t5_push_latency", 64'(lat), 64'(9));
    chk("t5_sample", 64'(smp_data), 64'(2054));
    chk("t5_busy", 64'({busy, done}), 64'(2));
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_reset_outputs", 64'({ro_en, ro_clr, smp_valid, busy, done, smp_data}), 64'(0));
    cnt = 0;
    repeat (8) begin
      tick();
      if (smp_valid !== 1'b0 || ro_en !== 1'b0 || ro_clr !== 1'b0 || busy !== 1'b0) cnt++;
    end
    chk("t5_quiet_after_rst", 64'(cnt), 64'(0));
    smp_ready = 1'b1;

    // New run after reset: N=1, C=3 -> 2304+3, 1+6 cycles
    exp_q.push_back(32'd2307);
    run(1, 3, 0, 7, "t6_after_rst");

    // Restart from DONE: N=1, C=2 -> 2560+2, 1+5 cycles
    exp_q.push_back(32'd2562);
    run(1, 2, 0, 6, "t7_from_done");

    tick();
    tick();
    chk("clr_pulses", 64'(clr_total), 64'(10));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ro_sample_ctrl.md
RO_SAMPLE_CTRL -- requirements
Module: ro_sample_ctrl

Interface
REQ-001 SHALL have parameter SIZE_WIDTH, default 17: width of num_samples and collect_cycles.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of the ring-oscillator count and sample data.
REQ-003 SHALL have ports in this order and form:
- clk  input  1: the single clock.
- rst  input  1: reset, synchronous and active-high.
- go  input  1: single-cycle start pulse from the memory map.
- num_samples  input  SIZE_WIDTH: samples to produce per run.
- collect_cycles  input  SIZE_WIDTH: clk cycles per counting window.
- ro_count  input  CNT_WIDTH: ring-oscillator counter value, already synchronous to clk.
- ro_en  output  1: enables ring-oscillator counting.
- ro_clr  output  1: clears the ring-oscillator counter.
- smp_valid  output  1: a sample is offered downstream.
- smp_data  output  CNT_WIDTH: the offered sample.
- smp_ready  input  1: downstream (DMA write path) accepts the sample.
- busy  output  1: a run is in progress.
- done  output  1: the run has completed.

Function
REQ-004 SHALL implement the FSM states IDLE, CLEAR, COLLECT, SETTLE, PUSH and DONE.
REQ-005 SHALL, when go=1 in IDLE or DONE, latch num_samples as N and collect_cycles as C (C=0 latched as 1), clear the sample counter, clear done, and enter CLEAR next cycle (or DONE if N=0).
REQ-006 SHALL, for N=0, enter DONE one cycle after go, with no ro_clr and no smp_valid.
REQ-007 SHALL assert ro_clr for exactly one cycle in CLEAR, then enter COLLECT.
REQ-008 SHALL assert ro_en for exactly C consecutive cycles in COLLECT, timed by a loadable down-counter, then enter SETTLE.
REQ-009 SHALL hold ro_en=0 in SETTLE for one cycle, register ro_count into smp_data at the end of SETTLE, and enter PUSH.
REQ-010 SHALL assert smp_valid only in PUSH, holding smp_data stable while smp_valid=1 and smp_ready=0.
REQ-011 SHALL complete a transfer on a cycle with smp_valid=1 and smp_ready=1, then increment the sample counter and enter DONE if the count equals N, else CLEAR.
REQ-012 SHALL take C+3 cycles minimum per sample when smp_ready is held high.
REQ-013 SHALL ignore go in CLEAR, COLLECT, SETTLE and PUSH; changes on num_samples or collect_cycles mid-run SHALL have no effect.
REQ-014 SHALL drive busy=1 in CLEAR, COLLECT, SETTLE and PUSH only.
REQ-015 SHALL hold done=1 in DONE until the next accepted go or reset.
REQ-016 SHALL size the sample counter to SIZE_WIDTH+1 bits so that N=2**SIZE_WIDTH-1 completes without wrap.

Reset
REQ-017 SHALL, on rst=1 at a clk edge, enter IDLE and drive ro_en, ro_clr, smp_valid, busy and done to 0 and smp_data to 0.
REQ-018 SHALL abort a run on reset mid-operation, producing no further smp_valid until a new go.
REQ-019 SHALL treat go coincident with rst as ignored.

Structure
REQ-020 SHALL place the state enum typedef and the default SIZE_WIDTH/CNT_WIDTH constants in shared package ro_ctrl_pkg.
REQ-021 SHALL implement the COLLECT window timer as sub-module ro_window_timer (load, decrement, zero flag).

Verification
REQ-022 SHALL pass: go with N=3, C=10, smp_ready=1 -> three one-cycle ro_clr pulses, ro_en high 10 cycles each, 3 samples equal to the ro_count values captured in SETTLE, done at cycle 40 after go.
REQ-023 SHALL pass: go with N=0 -> done=1 one cycle later, with no ro_en and no smp_valid.
REQ-024 SHALL pass: go with N=2, C=0 -> ro_en high exactly 1 cycle per sample, 2 samples out.
REQ-025 SHALL pass: N=2, C=4, smp_ready low 5 cycles during the first PUSH -> smp_data stable, no second ro_clr until the transfer completes.
REQ-026 SHALL pass: a second go during COLLECT, and rst asserted in PUSH -> the second go is ignored; after reset, all outputs are 0, no smp_valid appears, and a new go runs normally.
